// File: rtl/sccb_slave_regfile_if.sv
// SCCB pin pair plus the register-file write report and debug read port of the responder.
interface sccb_slave_regfile_if;
    localparam int unsigned DW = 8;

    logic          scl_in;
    logic          sda_in;
    logic          sda_oe;
    logic          wr_strobe;
    logic [DW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic [DW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport slave (
        input  scl_in, sda_in, dbg_addr,
        output sda_oe, wr_strobe, wr_addr, wr_data, busy, dbg_data
    );

    modport master (
        output scl_in, sda_in, dbg_addr,
        input  sda_oe, wr_strobe, wr_addr, wr_data, busy, dbg_data
    );
endinterface

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C responder backed by a 256 x 8 register file; stands in for the camera
// so the sensor configuration path can run without a real sensor attached.
module sccb_slave_regfile #(
    parameter logic [7:0] DEVICE_ID = 8'h42
) (
    input  logic                       clk,
    input  logic                       rst,
    sccb_slave_regfile_if.slave        bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned BCW   = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-2:0]  shift_q, shift_d;
    logic [DW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  rd_byte_q, rd_byte_d;
    logic           rd_mode_q, rd_mode_d;
    logic           sda_oe_q, sda_oe_d;
    logic           busy_q, busy_d;
    logic           wr_strobe_q, wr_strobe_d;
    logic [DW-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]  wr_data_q, wr_data_d;
    logic [DW-1:0]  regs_q [DEPTH];

    logic scl_s1_q, scl_s2_q, scl_d_q;
    logic sda_s1_q, sda_s2_q, sda_d_q;

    logic          scl_rise_c, scl_fall_c, start_c, stop_c, reg_we_c;
    logic [DW-1:0] rx_byte_c, cur_byte_c;
    logic [2:0]    rd_idx_c;

    // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d_q  <= 1'b1;
        end else begin
            scl_s1_q <= bus.scl_in;
            scl_s2_q <= scl_s1_q;
            scl_d_q  <= scl_s2_q;
            sda_s1_q <= bus.sda_in;
            sda_s2_q <= sda_s1_q;
            sda_d_q  <= sda_s2_q;
        end
    end

    assign scl_rise_c = scl_s2_q & ~scl_d_q;
    assign scl_fall_c = ~scl_s2_q & scl_d_q;
    assign start_c    = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    assign stop_c     = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
    assign rx_byte_c  = {shift_q, sda_s2_q};
    assign cur_byte_c = regs_q[ptr_q];
    assign rd_idx_c   = 3'(4'd7 - bit_cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rd_byte_q   <= '0;
            rd_mode_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rd_byte_q   <= rd_byte_d;
            rd_mode_q   <= rd_mode_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Bus protocol FSM; START/STOP override any bit activity in every state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rd_byte_d   = rd_byte_q;
        rd_mode_d   = rd_mode_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we_c    = 1'b0;

        if (start_c) begin
            state_d   = S_ID;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_c) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                S_ID, S_SUB, S_WDATA: begin
                    if (scl_rise_c) begin
                        shift_d   = rx_byte_c[DW-2:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == S_ID) begin
                                if (rx_byte_c == DEVICE_ID) begin
                                    rd_mode_d = 1'b0;
                                    state_d   = S_ID_ACK;
                                end else if (rx_byte_c == (DEVICE_ID | 8'h01)) begin
                                    rd_mode_d = 1'b1;
                                    state_d   = S_ID_ACK;
                                end else begin
                                    state_d   = S_WAIT_STOP;
                                end
                            end else if (state_q == S_SUB) begin
                                ptr_d   = rx_byte_c;
                                state_d = S_SUB_ACK;
                            end else begin
                                reg_we_c    = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte_c;
                                ptr_d       = ptr_q + 8'd1;
                                state_d     = S_WDATA_ACK;
                            end
                        end
                    end
                end

                // Ack slot: bit_cnt 0 waits for the fall after bit 8, 1 holds SDA low.
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == S_ID_ACK && rd_mode_q) begin
                                rd_byte_d = cur_byte_c;
                                sda_oe_d  = ~cur_byte_c[7];
                                bit_cnt_d = 4'd1;
                                state_d   = S_RDATA;
                            end else if (state_q == S_ID_ACK) begin
                                state_d = S_SUB;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == 4'd0) begin
                            rd_byte_d = cur_byte_c;
                            sda_oe_d  = ~cur_byte_c[7];
                            bit_cnt_d = 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_oe_d  = ~rd_byte_q[rd_idx_c];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise_c) begin
                        state_d = sda_s2_q ? S_WAIT_STOP : S_RDATA;
                    end
                end

                S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Register file, written on the same edge that raises wr_strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[8'(i)] <= '0;
            end
        end else if (reg_we_c) begin
            regs_q[ptr_q] <= rx_byte_c;
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_data  = regs_q[bus.dbg_addr];

endmodule

// File: doc/sccb_slave_regfile.md
# sccb_slave_regfile

SCCB/I2C responder with an internal 256 x 8 register file. It is the camera-side end of the SCCB link that our config LUT and I2C master drive. The block lets the OV7725 configuration path run in simulation and on-board loopback without a sensor. Every write the master issues lands in the register file and is reported on a strobe, and reads return the stored values.

## Interface
- DEVICE_ID, 8'h42, 8-bit write address; read address is DEVICE_ID|1 (8'h43)
- clk  input  1  system clock; must be >= 16x SCL frequency
- rst  input  1  asynchronous, active-high reset
- scl_in  input  1  SCL from bus (asynchronous)
- sda_in  input  1  SDA from bus (asynchronous)
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain, top level ties pad)
- wr_strobe  output  1  one-cycle pulse when a data byte is committed
- wr_addr  output  8  register address of the committed byte
- wr_data  output  8  committed byte
- busy  output  1  high from START until STOP or abort
- dbg_addr  input  8  debug read address
- dbg_data  output  8  combinational reg[dbg_addr]

## Operation
- scl_in and sda_in pass through 2-flop synchronizers, then 1-flop edge detect (scl_rise, scl_fall).
- START = synced SDA falls while synced SCL high. STOP = synced SDA rises while synced SCL high.
- STOP in any state -> IDLE, sda_oe=0, busy=0.
- START in any state, including a repeated START -> ID, bit count 0, sda_oe=0, busy=1.
- Data bits are sampled MSB first on scl_rise. sda_oe changes only on scl_fall.
- State machine:
  - IDLE: wait for START.
  - ID: shift 8 bits. If byte == DEVICE_ID -> ID_ACK (write). If byte == DEVICE_ID|1 -> ID_ACK (read). Otherwise -> WAIT_STOP with no ack.
  - ID_ACK: drive sda_oe=1 from the scl_fall after bit 8 to the next scl_fall. Write -> SUB. Read -> RDATA.
  - SUB: shift 8 bits into the address pointer, then SUB_ACK (ack as above) -> WDATA.
  - WDATA: shift 8 bits. At scl_rise of bit 8: reg[ptr] <= byte, wr_strobe pulse, ptr <= ptr+1 (8-bit wrap, 8'hFF -> 8'h00). Then WDATA_ACK -> WDATA (burst).
  - RDATA: on each scl_fall, sda_oe = ~current bit of reg[ptr], MSB first. Byte is latched at the first scl_fall. After 8 bits, release on scl_fall, ptr <= ptr+1, -> RD_ACK.
  - RD_ACK: sample SDA on scl_rise. 0 (ACK) -> RDATA with the next byte. 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: sda_oe=0; ignore bits until STOP or START.
- 2-phase write (ID, sub-address, STOP) only loads ptr; no register write.
- ptr persists across transactions; reset value 8'h00.
- STOP or START mid-byte discards the partial byte; no write, ptr unchanged.
- The ack after a data byte is always driven. SCCB don't-care bit is treated as I2C ACK.

## Timing
- Reset values:
  - sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0
  - state=IDLE, ptr=0
  - all 256 registers = 8'h00
  - dbg_data = 0
- Bus pin to internal event latency: 3 clk (2 sync + 1 edge).
- wr_strobe is high for exactly 1 clk, in the cycle after scl_rise of bit 8 is detected. wr_addr/wr_data are valid in that cycle and hold until the next strobe. reg[] is updated the same edge.
- sda_oe asserts/releases 1 clk after the detected scl_fall. This guarantees setup before the next SCL rise at >= 16x oversampling.
- Simultaneous START/STOP and bit edge: START/STOP take priority; a scl_rise cannot coincide with them by definition (SCL high).
- Reset mid-transaction releases SDA immediately (asynchronous).

## Test plan
- 3-phase write: START, 0x42, 0x12, 0x46, STOP -> sda_oe low in 3 ack slots; one wr_strobe with wr_addr=0x12, wr_data=0x46; dbg_addr=0x12 gives 0x46; busy low after STOP.
- Read-back: 2-phase write of sub-address 0x12, STOP, then START, 0x43, master NACK, STOP -> SDA carries 0x46 MSB first; no wr_strobe; next read returns reg[0x13]=0x00.
- Wrong ID: START, 0x60, 0x12, 0x46, STOP -> sda_oe never asserts; no wr_strobe; reg[0x12] unchanged.
- Burst with wrap: START, 0x42, 0xFE, 0xAA, 0xBB, 0xCC, STOP -> strobes at 0xFE=0xAA, 0xFF=0xBB, 0x00=0xCC.
- Abort mid-byte: START, 0x42, 0x20, 4 data bits, STOP -> no strobe; state IDLE; then a full write to 0x20=0x5A succeeds.
- Reset during RDATA while sda_oe=1 -> sda_oe=0 immediately; busy=0; dbg_data at 0x12 = 0x00.
